// File: rtl/sipo_deframer.sv
// LSB-first serial receiver: aligns on frame_start, assembles W-bit words into a one-entry
// valid/ready output register, and reports sticky overrun / framing errors.
module sipo_deframer #(
    parameter int W          = 4,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ser_in,
    input  logic         ser_valid,
    input  logic         frame_start,
    output logic [W-1:0] data_out,
    output logic         data_valid,
    input  logic         data_ready,
    output logic         overrun,
    output logic         frame_err,
    input  logic         err_clr
);

    localparam int CW = $clog2(W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, pos;
    logic [W-1:0]    shreg, word;
    logic            take, complete, realign_err, load, ovr_evt;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pos         = '0;
        take        = 1'b0;
        complete    = 1'b0;
        realign_err = 1'b0;
        if (ser_valid) begin
            if (frame_start) begin
                // A marker always restarts at bit 0; mid-word it also discards the partial word.
                take        = 1'b1;
                pos         = '0;
                cnt_nxt     = CW'(1);
                state_nxt   = SHIFT;
                realign_err = (state == SHIFT) && (cnt != '0);
            end else if (state == SHIFT) begin
                take = 1'b1;
                pos  = cnt;
                if (cnt == CW'(W - 1)) begin
                    complete  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = CONTINUOUS ? SHIFT : IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
        end

        word = shreg;
        for (int i = 0; i < W; i++) begin
            if (take && pos == CW'(i)) begin
                word[i] = ser_in;
            end
        end

        // The output slot is free if empty or being drained on this same edge.
        load    = complete && (!data_valid || data_ready);
        ovr_evt = complete && data_valid && !data_ready;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt        <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            shreg <= word;
            if (load) begin
                data_out   <= word;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            overrun   <= ovr_evt     | (overrun   & ~err_clr);
            frame_err <= realign_err | (frame_err & ~err_clr);
        end
    end

endmodule

// File: doc/sipo_deframer.md
# sipo_deframer

Serial-to-parallel receive stage sitting directly downstream of the 4-bit parallel-to-serial shift register. It samples the LSB-first serial stream, qualified by the same shift-enable the transmitter uses, and aligns words on a frame-start marker. It reassembles each W-bit word and presents it on a one-entry valid/ready output register. Framing and overflow errors are reported through sticky flags.

## Interface
- W, 4: word width in bits (2..16).
- CONTINUOUS, 0: 0 = every word needs its own frame_start; 1 = after a word completes, the next qualified bit is bit 0 of the next word.
- clk  in  1  single clock, all logic on rising edge.
- clr  in  1  synchronous active-high reset.
- ser_in  in  1  serial data from the upstream shifter output (LSB first).
- ser_valid  in  1  bit qualifier; ser_in is sampled only on cycles where ser_valid=1.
- frame_start  in  1  marks the current qualified bit as bit 0 of a new word; ignored when ser_valid=0.
- data_out  out  W  assembled word; stable while data_valid=1.
- data_valid  out  1  data_out holds an unconsumed word.
- data_ready  in  1  consumer accepts the word when data_valid & data_ready.
- overrun  out  1  sticky: a completed word was dropped because the output register was full.
- frame_err  out  1  sticky: frame_start arrived while a word was partially collected.
- err_clr  in  1  clears overrun and frame_err.

## Operation
- Reset (clr=1 at rising edge): state IDLE, bit counter 0, shift register 0, data_out=0, data_valid=0, overrun=0, frame_err=0. clr overrides every other input.
- IDLE: qualified bits without frame_start are discarded. A qualified bit with frame_start stores ser_in into bit 0, sets counter=1, and moves to SHIFT.
- SHIFT: each qualified bit is written to position counter and the counter increments. Non-qualified cycles hold all state.
- Word completion: the qualified bit written to position W-1 completes the word. The counter wraps to 0. The state moves to IDLE if CONTINUOUS=0 and stays in SHIFT if CONTINUOUS=1.
- Transfer: on completion, the word loads into data_out and data_valid=1 if the output register is empty, or if it is being consumed in the same cycle (data_valid & data_ready). Otherwise the word is dropped, data_out is unchanged, and overrun is set.
- Consumption: data_valid & data_ready with no completion in the same cycle gives data_valid=0 next cycle. data_out retains its last value.
- frame_start in SHIFT with counter≠0: the partial word is discarded, frame_err is set, and the current bit becomes bit 0 of a new word (counter=1).
- frame_start in SHIFT with counter=0 (CONTINUOUS=1, word boundary): normal alignment, no error.
- err_clr clears both flags. If err_clr and a new error event occur in the same cycle, the error event wins and the flag stays 1.
- W=1 is not supported. For W≥2, the counter is ceil(log2(W)) bits wide.

## Timing
- Latency: data_valid and the new data_out appear on the rising edge that samples the final bit, i.e. visible the cycle after the last qualified bit is presented.
- Minimum word period is W cycles (ser_valid held 1). Back-to-back words with data_ready held 1 sustain full throughput with no drops.
- data_ready may be asserted without data_valid and has no effect.
- Flags update on the same edge as the causing event.
- A clr asserted mid-word or while data_valid=1 discards everything. Outputs take their reset values on that edge.

## Test plan
- Basic word (W=4, CONTINUOUS=0): frame_start with bits 1,1,0,1 on 4 consecutive qualified cycles -> data_out=4'hB, data_valid=1 one cycle after the 4th bit. data_ready=1 -> data_valid=0 next cycle.
- Gapped bits: the same word with ser_valid=0 gaps of 1–3 cycles between bits -> still 4'hB. No bits are taken from gap cycles.
- Continuous stream (CONTINUOUS=1, data_ready=1): a single frame_start, then 12 qualified bits encoding 4'h3, 4'hA, 4'h5 -> three consecutive words with no drops and flags 0.
- Overrun: complete 4'h7 with data_ready=0, then complete 4'h9 -> data_out stays 4'h7 and overrun=1. Then data_ready=1 consumes 4'h7. err_clr -> overrun=0.
- Realign: frame_start, bits 1,0, then frame_start with bits 0,0,1,1 -> frame_err=1, and data_out=4'hC.
- Reset mid-word: frame_start, 2 bits, clr=1 for one cycle, then ser_valid bits without frame_start -> data_valid stays 0. A fresh frame_start + 4'h6 -> data_out=4'h6.
